axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester arbiter for the core's single AXI4 read master port. It accepts read requests from instruction fetch (IF) and load/store (LS) over valid/ready handshakes and grants one transaction at a time, round-robin. It drives the AR channel, collects the R beat and routes the response back to the requester that owns the transaction. It sits between the pipeline's fetch/memory stages and the AXI interconnect, and replaces the fixed instruction-then-data sequencing in the pipeline's bus interface.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, read data width
- TIMEOUT, 255, max cycles waiting in R state before an error response; 0 disables the timeout
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- if_req_valid / if_req_ready  in / out  1  IF request handshake
- if_req_addr  in  ADDR_W  IF fetch address
- if_resp_valid  out  1  IF response pulse
- if_resp_data  out  DATA_W  IF response data
- if_resp_err  out  1  IF response error
- ls_req_valid / ls_req_ready  in / out  1  LS request handshake
- ls_req_addr  in  ADDR_W  LS load address
- ls_req_size  in  3  LS AxSIZE encoding
- ls_resp_valid  out  1  LS response pulse
- ls_resp_data  out  DATA_W  LS response data
- ls_resp_err  out  1  LS response error
- ARID  out  4  transaction ID: 0 = IF, 1 = LS
- ARADDR  out  ADDR_W  read address
- ARLEN  out  8  burst length, always 0
- ARSIZE  out  3  transfer size: IF = 3'b010, LS = ls_req_size
- ARBURST  out  2  burst type, always INCR (2'b01)
- ARPROT  out  3  protection: IF = 3'b100, LS = 3'b000
- ARVALID / ARREADY  out / in  1  AR channel handshake
- RID  in  4  response ID
- RDATA  in  DATA_W  read data
- RRESP  in  2  read response
- RLAST  in  1  last beat
- RVALID / RREADY  in / out  1  R channel handshake

## Operation
- Three states:
  - IDLE: no transaction active.
  - AR: address phase. ARVALID=1; ARID, ARADDR, ARSIZE and ARPROT held stable.
  - R: data phase. RREADY=1.
- **Arbitration in IDLE**
  - The grant is combinational from the request valids and the last_grant register.
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester that is not last_grant wins.
  - The granted requester sees its req_ready=1. The non-granted requester's req_ready is 0.
  - req_ready is 0 in every state other than IDLE.
- **Accept** (valid & ready in IDLE)
  - Latch the owner, the address, and the ARSIZE/ARPROT/ARID values for that requester.
  - Set last_grant to the owner.
  - Go to AR.
  - The requester does not need to hold its address after the accept cycle.
- **AR state**: when ARREADY=1, go to R.
- **R state**: a beat is accepted when RVALID=1.
  - If RLAST=1, the owner's resp_valid is 1 for that cycle:
    - resp_data = RDATA.
    - resp_err = 1 if RRESP≠2'b00 or RID≠latched ID.
    - Next state is IDLE.
  - If RLAST=0, the beat is consumed with no response and the state stays R. This is a protocol-error guard; it cannot occur with ARLEN=0.
- **Timeout** (TIMEOUT≠0)
  - A counter clears on entry to R and increments each R cycle without a completing beat.
  - When the counter equals TIMEOUT, the owner's resp_valid=1 with err=1 and data=0, and the state goes to IDLE.
  - AR is never aborted, so AXI rules are preserved.
- **Response bus**
  - Responses have no backpressure; requesters must accept a resp_valid pulse in the cycle it occurs.
  - The non-owner's resp_valid is always 0.
  - resp_data and resp_err are don't-care while resp_valid=0.

## Timing
- **Reset values**
  - state=IDLE, last_grant=LS, so IF wins the first tie.
  - Counter=0.
  - ARVALID=0, RREADY=0.
  - Both resp_valid=0.
  - ARID=0, ARADDR=0, ARLEN=0, ARSIZE=0, ARBURST=2'b01, ARPROT=0.
- **Latency**
  - Accept in cycle N; ARVALID=1 from N+1.
  - With ARREADY=1 at N+1, RREADY=1 from N+2.
  - With RVALID=RLAST=1 at N+2, resp_valid=1 at N+2 (combinational from R).
  - The next accept is possible at N+3. Best case is one transaction per 3 cycles.
- **Registers**: ARVALID, RREADY and all AR payload are registered. req_ready and resp_* are combinational.
- **Stray inputs**: RVALID in IDLE or AR is ignored (RREADY=0) and produces no response.
- **Reset mid-operation**: the state returns to IDLE next cycle, the transaction is dropped with no response, and ARVALID and RREADY go to 0. The interconnect is reset concurrently.

## Test plan
- **IF only**: addr 0x8000_0000, ARREADY=1, R beat 1 cycle later with RDATA=0x13, RID=0, RRESP=0 → ARID=0, ARSIZE=2, ARPROT=4, if_resp_valid with data 0x13, err=0. Total latency: accept + 2 cycles.
- **Simultaneous requests after reset**: both valid → IF granted first. Both held → LS granted second, with ARID=1, ARSIZE=ls_req_size, ARADDR=ls_req_addr. Both held → IF granted third (round-robin alternation).
- **ARREADY stall**: ARREADY held 0 for 5 cycles → ARVALID/ARADDR/ARID stable all 5 cycles, RREADY=0. ARREADY=1 → R state next cycle.
- **Error routing**:
  - LS transaction with RRESP=2'b10 → ls_resp_err=1, and IF sees no pulse.
  - LS transaction with RID=0 and RRESP=0 → ls_resp_err=1.
- **Timeout**: TIMEOUT=8, no RVALID → exactly 8 R cycles, then owner resp_valid with err=1 and data=0, and the next request is accepted.
- **Reset in R**: rstn=0 for 1 cycle while in R → no resp pulse, ARVALID=RREADY=0, last_grant=LS. A new IF request is accepted after reset.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Round-robin arbiter that shares the core's single AXI4 read master
//   between instruction fetch (IF) and load/store (LS). It handles one
//   single-beat transaction at a time and sends the R beat back to the
//   requester that owns the transaction.
//
// Ports
//   clk, rstn                    clock, synchronous active-low reset
//   if_req_valid/ready/addr      IF request handshake and fetch address
//   if_resp_valid/data/err       IF response pulse (no backpressure)
//   ls_req_valid/ready/addr/size LS request handshake, address and AxSIZE
//   ls_resp_valid/data/err       LS response pulse (no backpressure)
//   AR*                          AXI read address channel (registered)
//   R*                           AXI read data channel
module axi_rd_arbiter #(
   parameter int unsigned ADDR_W  = 64,
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              if_req_valid,
   output logic              if_req_ready,
   input  logic [ADDR_W-1:0] if_req_addr,
   output logic              if_resp_valid,
   output logic [DATA_W-1:0] if_resp_data,
   output logic              if_resp_err,
   input  logic              ls_req_valid,
   output logic              ls_req_ready,
   input  logic [ADDR_W-1:0] ls_req_addr,
   input  logic [2:0]        ls_req_size,
   output logic              ls_resp_valid,
   output logic [DATA_W-1:0] ls_resp_data,
   output logic              ls_resp_err,
   output logic [3:0]        ARID,
   output logic [ADDR_W-1:0] ARADDR,
   output logic [7:0]        ARLEN,
   output logic [2:0]        ARSIZE,
   output logic [1:0]        ARBURST,
   output logic [2:0]        ARPROT,
   output logic              ARVALID,
   input  logic              ARREADY,
   input  logic [3:0]        RID,
   input  logic [DATA_W-1:0] RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic              RVALID,
   output logic              RREADY
);

   localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AR,
      ST_R
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_LS = 1'b1
   } req_e;

   state_e             state_q;
   req_e               owner_q;
   req_e               last_grant_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               arvalid_q;
   logic               rready_q;
   logic [3:0]         arid_q;
   logic [ADDR_W-1:0]  araddr_q;
   logic [2:0]         arsize_q;
   logic [2:0]         arprot_q;

   logic               timeout_en;
   logic               grant_if;
   logic               grant_ls;
   logic               beat_done;
   logic               timed_out;
   logic               resp_fire;
   logic [DATA_W-1:0]  resp_data;
   logic               resp_err;

   assign timeout_en = (TIMEOUT != 0);

   // On a tie the requester that did not win last time is granted.
   assign grant_if = if_req_valid & (~ls_req_valid | (last_grant_q == REQ_LS));
   assign grant_ls = ls_req_valid & (~if_req_valid | (last_grant_q == REQ_IF));

   assign if_req_ready = (state_q == ST_IDLE) & grant_if;
   assign ls_req_ready = (state_q == ST_IDLE) & grant_ls;

   // A last beat takes priority over a timeout hitting in the same cycle.
   assign beat_done = (state_q == ST_R) & RVALID & RLAST;
   assign timed_out = timeout_en & (state_q == ST_R) & (cnt_q == CNT_W'(TIMEOUT));
   assign resp_fire = beat_done | timed_out;

   always_comb begin
      resp_data = '0;
      resp_err  = 1'b1;
      if (beat_done) begin
         resp_data = RDATA;
         resp_err  = (RRESP != 2'b00) | (RID != arid_q);
      end
   end

   assign if_resp_valid = resp_fire & (owner_q == REQ_IF);
   assign ls_resp_valid = resp_fire & (owner_q == REQ_LS);
   assign if_resp_data  = resp_data;
   assign ls_resp_data  = resp_data;
   assign if_resp_err   = resp_err;
   assign ls_resp_err   = resp_err;

   assign ARID    = arid_q;
   assign ARADDR  = araddr_q;
   assign ARLEN   = 8'd0;
   assign ARSIZE  = arsize_q;
   assign ARBURST = 2'b01;
   assign ARPROT  = arprot_q;
   assign ARVALID = arvalid_q;
   assign RREADY  = rready_q;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= ST_IDLE;
         owner_q      <= REQ_IF;
         last_grant_q <= REQ_LS;
         cnt_q        <= '0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         arid_q       <= '0;
         araddr_q     <= '0;
         arsize_q     <= '0;
         arprot_q     <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_if | grant_ls) begin
                  owner_q      <= grant_ls ? REQ_LS : REQ_IF;
                  last_grant_q <= grant_ls ? REQ_LS : REQ_IF;
                  araddr_q     <= grant_ls ? ls_req_addr : if_req_addr;
                  arid_q       <= grant_ls ? 4'd1 : 4'd0;
                  arsize_q     <= grant_ls ? ls_req_size : 3'b010;
                  arprot_q     <= grant_ls ? 3'b000 : 3'b100;
                  arvalid_q    <= 1'b1;
                  state_q      <= ST_AR;
               end
            end
            ST_AR: begin
               if (ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= ST_R;
               end
            end
            ST_R: begin
               if (resp_fire) begin
                  rready_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end else if (timeout_en) begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
//   Directed bench for axi_rd_arbiter (TIMEOUT overridden to 8). Stimulus
//   tasks push the expected response into a scoreboard queue; a monitor on
//   the falling edge pops and compares whenever either resp_valid pulses.
module tb_axi_rd_arbiter;

   logic        clk;
   logic        rstn;
   logic        if_req_valid;
   logic        if_req_ready;
   logic [63:0] if_req_addr;
   logic        if_resp_valid;
   logic [63:0] if_resp_data;
   logic        if_resp_err;
   logic        ls_req_valid;
   logic        ls_req_ready;
   logic [63:0] ls_req_addr;
   logic [2:0]  ls_req_size;
   logic        ls_resp_valid;
   logic [63:0] ls_resp_data;
   logic        ls_resp_err;
   logic [3:0]  ARID;
   logic [63:0] ARADDR;
   logic [7:0]  ARLEN;
   logic [2:0]  ARSIZE;
   logic [1:0]  ARBURST;
   logic [2:0]  ARPROT;
   logic        ARVALID;
   logic        ARREADY;
   logic [3:0]  RID;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic        RVALID;
   logic        RREADY;

   axi_rd_arbiter #(
      .ADDR_W (64),
      .DATA_W (64),
      .TIMEOUT(8)
   ) dut (
      .clk          (clk),
      .rstn         (rstn),
      .if_req_valid (if_req_valid),
      .if_req_ready (if_req_ready),
      .if_req_addr  (if_req_addr),
      .if_resp_valid(if_resp_valid),
      .if_resp_data (if_resp_data),
      .if_resp_err  (if_resp_err),
      .ls_req_valid (ls_req_valid),
      .ls_req_ready (ls_req_ready),
      .ls_req_addr  (ls_req_addr),
      .ls_req_size  (ls_req_size),
      .ls_resp_valid(ls_resp_valid),
      .ls_resp_data (ls_resp_data),
      .ls_resp_err  (ls_resp_err),
      .ARID         (ARID),
      .ARADDR       (ARADDR),
      .ARLEN        (ARLEN),
      .ARSIZE       (ARSIZE),
      .ARBURST      (ARBURST),
      .ARPROT       (ARPROT),
      .ARVALID      (ARVALID),
      .ARREADY      (ARREADY),
      .RID          (RID),
      .RDATA        (RDATA),
      .RRESP        (RRESP),
      .RLAST        (RLAST),
      .RVALID       (RVALID),
      .RREADY       (RREADY)
   );

   typedef struct {
      bit          ls;
      logic [63:0] data;
      bit          err;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
      end
   endfunction

   // Response monitor: every pulse must match the oldest expected response.
   always @(negedge clk) begin
      exp_t e;
      if (if_resp_valid || ls_resp_valid) begin
         chk("resp_single_owner", 64'(if_resp_valid & ls_resp_valid), 64'(0));
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL resp_unexpected actual=if:%0d,ls:%0d required=none t=%0t",
                     if_resp_valid, ls_resp_valid, $time);
         end else begin
            e = sb.pop_front();
            chk("resp_port_ls", 64'(ls_resp_valid), 64'(e.ls));
            chk("resp_data", ls_resp_valid ? ls_resp_data : if_resp_data, e.data);
            chk("resp_err", 64'(ls_resp_valid ? ls_resp_err : if_resp_err), 64'(e.err));
         end
      end
   end

   // Wait for the owner's grant, accept, then check the AR phase while
   // ARREADY is held low for 'stall' cycles. Returns in the first R cycle.
   task automatic issue(input bit own_ls, input bit drop, input logic [63:0] exp_addr,
                        input logic [2:0] exp_size, input logic [2:0] exp_prot, input int stall);
      int n;
      n = 0;
      @(negedge clk);
      while (!(own_ls ? ls_req_ready : if_req_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_owner", 64'(own_ls ? ls_req_ready : if_req_ready), 64'(1));
      chk("req_ready_other", 64'(own_ls ? if_req_ready : ls_req_ready), 64'(0));
      @(posedge clk);
      #1;
      if (drop) begin
         if (own_ls) begin
            ls_req_valid = 1'b0;
            ls_req_addr  = '1;
         end else begin
            if_req_valid = 1'b0;
            if_req_addr  = '1;
         end
      end
      ARREADY = (stall == 0);
      for (int i = 0; i <= stall; i++) begin
         @(negedge clk);
         chk("ar_valid", 64'(ARVALID), 64'(1));
         chk("ar_id", 64'(ARID), 64'(own_ls));
         chk("ar_addr", ARADDR, exp_addr);
         chk("ar_size", 64'(ARSIZE), 64'(exp_size));
         chk("ar_prot", 64'(ARPROT), 64'(exp_prot));
         chk("ar_len", 64'(ARLEN), 64'(0));
         chk("ar_burst", 64'(ARBURST), 64'(1));
         chk("ar_rready", 64'(RREADY), 64'(0));
         chk("ar_if_ready", 64'(if_req_ready), 64'(0));
         chk("ar_ls_ready", 64'(ls_req_ready), 64'(0));
         @(posedge clk);
         #1;
         ARREADY = (i + 1 == stall);
      end
   endtask

   // R phase: r_delay cycles of no beat (or a stray non-last beat), then the
   // last beat. The expected response is queued for the monitor.
   task automatic complete(input bit own_ls, input logic [63:0] rdata, input logic [3:0] rid,
                           input logic [1:0] rresp, input bit exp_err, input int r_delay,
                           input bit junk_beats);
      for (int i = 0; i < r_delay; i++) begin
         RVALID = junk_beats;
         RLAST  = 1'b0;
         RDATA  = 64'hDEAD;
         RID    = rid;
         RRESP  = 2'b00;
         @(negedge clk);
         chk("r_rready", 64'(RREADY), 64'(1));
         chk("r_arvalid", 64'(ARVALID), 64'(0));
         @(posedge clk);
         #1;
      end
      RVALID = 1'b1;
      RLAST  = 1'b1;
      RDATA  = rdata;
      RID    = rid;
      RRESP  = rresp;
      sb.push_back('{ls: own_ls, data: rdata, err: exp_err});
      @(negedge clk);
      chk("r_rready_beat", 64'(RREADY), 64'(1));
      @(posedge clk);
      #1;
      RVALID = 1'b0;
      RLAST  = 1'b0;
      RDATA  = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int  n;
      bit  seen;
      rstn         = 1'b0;
      if_req_valid = 1'b0;
      if_req_addr  = '0;
      ls_req_valid = 1'b0;
      ls_req_addr  = '0;
      ls_req_size  = '0;
      ARREADY      = 1'b0;
      RID          = '0;
      RDATA        = '0;
      RRESP        = '0;
      RLAST        = 1'b0;
      RVALID       = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", 64'(ARVALID), 64'(0));
      chk("rst_rready", 64'(RREADY), 64'(0));
      chk("rst_arid", 64'(ARID), 64'(0));
      chk("rst_araddr", ARADDR, 64'(0));
      chk("rst_arlen", 64'(ARLEN), 64'(0));
      chk("rst_arsize", 64'(ARSIZE), 64'(0));
      chk("rst_arburst", 64'(ARBURST), 64'(1));
      chk("rst_arprot", 64'(ARPROT), 64'(0));
      chk("rst_if_resp", 64'(if_resp_valid), 64'(0));
      chk("rst_ls_resp", 64'(ls_resp_valid), 64'(0));
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Tie after reset: IF, then LS, then IF again
      if_req_valid = 1'b1;
      if_req_addr  = 64'h1000;
      ls_req_valid = 1'b1;
      ls_req_addr  = 64'h2000;
      ls_req_size  = 3'b001;
      issue(1'b0, 1'b0, 64'h1000, 3'b010, 3'b100, 0);
      complete(1'b0, 64'h11, 4'd0, 2'b00, 1'b0, 0, 1'b0);
      issue(1'b1, 1'b0, 64'h2000, 3'b001, 3'b000, 0);
      complete(1'b1, 64'h22, 4'd1, 2'b00, 1'b0, 0, 1'b0);
      issue(1'b0, 1'b1, 64'h1000, 3'b010, 3'b100, 0);
      ls_req_valid = 1'b0;
      complete(1'b0, 64'h33, 4'd0, 2'b00, 1'b0, 0, 1'b0);

      // Stray R beat while idle: RREADY low, no response
      RVALID = 1'b1;
      RLAST  = 1'b1;
      RDATA  = 64'hBAD;
      repeat (2) begin
         @(negedge clk);
         chk("stray_rready", 64'(RREADY), 64'(0));
         @(posedge clk);
         #1;
      end
      RVALID = 1'b0;
      RLAST  = 1'b0;

      // IF only, best-case latency
      if_req_valid = 1'b1;
      if_req_addr  = 64'h8000_0000;
      issue(1'b0, 1'b1, 64'h8000_0000, 3'b010, 3'b100, 0);
      complete(1'b0, 64'h13, 4'd0, 2'b00, 1'b0, 0, 1'b0);

      // ARREADY stall of 5 cycles, then delayed R with a non-last beat
      ls_req_valid = 1'b1;
      ls_req_addr  = 64'h0000_0040_0000_1238;
      ls_req_size  = 3'b011;
      issue(1'b1, 1'b1, 64'h0000_0040_0000_1238, 3'b011, 3'b000, 5);
      complete(1'b1, 64'hCAFE_F00D_1234_5678, 4'd1, 2'b00, 1'b0, 2, 1'b1);

      // Error routing: SLVERR, then ID mismatch
      ls_req_valid = 1'b1;
      ls_req_addr  = 64'h5008;
      ls_req_size  = 3'b010;
      issue(1'b1, 1'b1, 64'h5008, 3'b010, 3'b000, 0);
      complete(1'b1, 64'h77, 4'd1, 2'b10, 1'b1, 0, 1'b0);
      ls_req_valid = 1'b1;
      ls_req_addr  = 64'h5010;
      ls_req_size  = 3'b000;
      issue(1'b1, 1'b1, 64'h5010, 3'b000, 3'b000, 0);
      complete(1'b1, 64'h88, 4'd0, 2'b00, 1'b1, 0, 1'b0);

      // Timeout: 8 R cycles with no beat, then error pulse with zero data
      ls_req_valid = 1'b1;
      ls_req_addr  = 64'h3000;
      ls_req_size  = 3'b010;
      issue(1'b1, 1'b1, 64'h3000, 3'b010, 3'b000, 0);
      sb.push_back('{ls: 1'b1, data: 64'h0, err: 1'b1});
      n    = 0;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         if (ls_resp_valid) seen = 1'b1;
         else if (RREADY) n++;
      end
      chk("timeout_seen", 64'(seen), 64'(1));
      chk("timeout_rcycles", 64'(n), 64'(8));
      @(posedge clk);
      #1;
      if_req_valid = 1'b1;
      if_req_addr  = 64'h4000;
      issue(1'b0, 1'b1, 64'h4000, 3'b010, 3'b100, 0);
      complete(1'b0, 64'h44, 4'd0, 2'b00, 1'b0, 0, 1'b0);

      // Reset while in R: no response, outputs cleared, last_grant back to LS
      if_req_valid = 1'b1;
      if_req_addr  = 64'h6000;
      issue(1'b0, 1'b1, 64'h6000, 3'b010, 3'b100, 0);
      rstn = 1'b0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      @(negedge clk);
      chk("rstr_arvalid", 64'(ARVALID), 64'(0));
      chk("rstr_rready", 64'(RREADY), 64'(0));
      chk("rstr_araddr", ARADDR, 64'(0));
      chk("rstr_arid", 64'(ARID), 64'(0));
      @(posedge clk);
      #1;
      if_req_valid = 1'b1;
      if_req_addr  = 64'h7000;
      ls_req_valid = 1'b1;
      ls_req_addr  = 64'h7100;
      ls_req_size  = 3'b000;
      issue(1'b0, 1'b1, 64'h7000, 3'b010, 3'b100, 0);
      complete(1'b0, 64'h99, 4'd0, 2'b00, 1'b0, 0, 1'b0);
      issue(1'b1, 1'b1, 64'h7100, 3'b000, 3'b000, 0);
      complete(1'b1, 64'hAA, 4'd1, 2'b00, 1'b0, 0, 1'b0);

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
